// File: rtl/mac_pkg.sv
// Shared types and default sizing for the pipelined multiply-accumulate block.
package mac_pkg;

  localparam int MAC_WIDTH_DEF = 8;
  localparam int MAC_GUARD_DEF = 4;

  typedef enum logic {
    MAC_MADD = 1'b0,
    MAC_ACC  = 1'b1
  } mac_mode_e;

endpackage

// File: rtl/mac_mult_stage.sv
// Pipeline stage 1: registered unsigned multiplier that also carries the
// addend and control bits alongside the product; holds while en_i is low.
module mac_mult_stage
  import mac_pkg::*;
#(
  parameter int WIDTH = MAC_WIDTH_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               valid_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [WIDTH-1:0]   c_i,
  input  logic               mode_i,
  input  logic               clr_i,
  output logic               valid_o,
  output logic [2*WIDTH-1:0] prod_o,
  output logic [WIDTH-1:0]   c_o,
  output mac_mode_e          mode_o,
  output logic               clr_o
);

  logic               valid_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   c_q;
  mac_mode_e          mode_q;
  logic               clr_q;

  assign prod_d = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Payload only loads on an accepted beat; an empty advance just drops valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      prod_q  <= '0;
      c_q     <= '0;
      mode_q  <= MAC_MADD;
      clr_q   <= 1'b0;
    end else if (en_i) begin
      valid_q <= valid_i;
      if (valid_i) begin
        prod_q <= prod_d;
        c_q    <= c_i;
        mode_q <= mac_mode_e'(mode_i);
        clr_q  <= clr_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign prod_o  = prod_q;
  assign c_o     = c_q;
  assign mode_o  = mode_q;
  assign clr_o   = clr_q;

endmodule

// File: rtl/pipelined_mac.sv
// Two-stage valid/ready multiply-add / multiply-accumulate pipeline.
// Define MAC_SATURATE_EN to clamp overflowing ACC results instead of wrapping.
module pipelined_mac
  import mac_pkg::*;
#(
  parameter  int WIDTH = MAC_WIDTH_DEF,
  parameter  int GUARD = MAC_GUARD_DEF,
  localparam int OUT_W = 2*WIDTH + GUARD
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  input  logic             mode_i,
  input  logic             clr_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] d_o,
  output logic             ovf_o
);

  logic               s1Valid;
  logic [2*WIDTH-1:0] s1Prod;
  logic [WIDTH-1:0]   s1C;
  mac_mode_e          s1Mode;
  logic               s1Clr;

  logic               s1Adv;
  logic               s2Adv;

  logic               valid_q;
  logic [OUT_W-1:0]   d_q;
  logic               ovf_q;
  logic [OUT_W-1:0]   acc_q;

  logic [OUT_W-1:0]   pExt;
  logic [OUT_W-1:0]   cExt;
  logic [OUT_W-1:0]   accBase;
  logic [OUT_W:0]     accSum;
  logic [OUT_W-1:0]   acc_d;
  logic [OUT_W-1:0]   res_d;
  logic               ovf_d;

  assign s2Adv   = !valid_q || ready_i;
  assign s1Adv   = !s1Valid || s2Adv;
  assign ready_o = s1Adv && !rst_i;

  mac_mult_stage #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (ready_o),
    .valid_i (valid_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .c_i     (c_i),
    .mode_i  (mode_i),
    .clr_i   (clr_i),
    .valid_o (s1Valid),
    .prod_o  (s1Prod),
    .c_o     (s1C),
    .mode_o  (s1Mode),
    .clr_o   (s1Clr)
  );

  // The sum keeps one extra carry bit so overflow is the true-sum test.
  always_comb begin
    pExt    = OUT_W'(s1Prod);
    cExt    = OUT_W'(s1C);
    accBase = s1Clr ? cExt : acc_q;
    accSum  = {1'b0, accBase} + {1'b0, pExt};
    acc_d   = acc_q;
    res_d   = pExt + cExt;
    ovf_d   = 1'b0;
    if (s1Mode == MAC_ACC) begin
      ovf_d = accSum[OUT_W];
`ifdef MAC_SATURATE_EN
      acc_d = accSum[OUT_W] ? {OUT_W{1'b1}} : accSum[OUT_W-1:0];
`else
      acc_d = accSum[OUT_W-1:0];
`endif
      res_d = acc_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      d_q     <= '0;
      ovf_q   <= 1'b0;
      acc_q   <= '0;
    end else if (s2Adv) begin
      valid_q <= s1Valid;
      if (s1Valid) begin
        d_q   <= res_d;
        ovf_q <= ovf_d;
        acc_q <= acc_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign d_o     = d_q;
  assign ovf_o   = ovf_q;

endmodule
